// File: rtl/usb_rx_linestate_pkg.sv
// Shared definitions for the USB full/low-speed receive line-state front-end:
// line-state encodings, default timeout constants and the pair decoder.
package usb_rx_linestate_pkg;

    // Line-state encodings as seen on rx_state
    typedef enum logic [1:0] {
        USB_LS_SE0 = 2'd0,
        USB_LS_J   = 2'd1,
        USB_LS_K   = 2'd2,
        USB_LS_SE1 = 2'd3
    } usb_line_state_e;

    // Bus reset: SE0 held for this many core cycles
    localparam int USB_DEFAULT_RST_CYCLES  = 120;
    // Suspend: idle J held for this many core cycles
    localparam int USB_DEFAULT_SUSP_CYCLES = 144000;

    // Decode a filtered {D+, D-} pair. Full speed idles with D+ high,
    // low speed idles with D- high, so J and K swap with the speed.
    function automatic usb_line_state_e decode_line_state(
        input logic dp,
        input logic dn,
        input logic low_speed
    );
        usb_line_state_e ls;
        case ({dp, dn})
            2'b00:   ls = USB_LS_SE0;
            2'b11:   ls = USB_LS_SE1;
            2'b10:   ls = low_speed ? USB_LS_K : USB_LS_J;
            default: ls = low_speed ? USB_LS_J : USB_LS_K;
        endcase
        return ls;
    endfunction

endpackage

// File: rtl/usb_line_filt.sv
// Run-length deglitch filter for one USB data line. Several raw samples
// arrive per clock (bit 0 oldest); the filtered value only flips after
// FILT_LEN consecutive opposite samples, and the run carries across clock
// boundaries so a glitch straddling two cycles is rejected too.
module usb_line_filt
    import usb_rx_linestate_pkg::*;
#(
    parameter int SAMPLES  = 2,
    parameter int FILT_LEN = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SAMPLES-1:0] samples,
    output logic               filtered,
    output logic               changed
);

    localparam int RUN_W = $clog2(FILT_LEN + 1);

    // Reject parameter values the sample loop was not built for
    if (!(SAMPLES == 1 || SAMPLES == 2 || SAMPLES == 4)) begin : g_bad_samples
        $error("usb_line_filt: SAMPLES must be 1, 2 or 4");
    end
    if (FILT_LEN < 1 || FILT_LEN > 8) begin : g_bad_filt_len
        $error("usb_line_filt: FILT_LEN must be in 1..8");
    end

    logic             filt_q;
    logic [RUN_W-1:0] run_q;
    logic             filt_nxt;
    logic [RUN_W-1:0] run_nxt;

    // Walk this cycle's samples oldest first, carrying value and run length
    always_comb begin
        filt_nxt = filt_q;
        run_nxt  = run_q;
        for (int i = 0; i < SAMPLES; i++) begin
            if (samples[i] == filt_nxt) begin
                run_nxt = '0;
            end else if (run_nxt == RUN_W'(FILT_LEN - 1)) begin
                filt_nxt = samples[i];
                run_nxt  = '0;
            end else begin
                run_nxt = run_nxt + 1'b1;
            end
        end
    end

    // Register filtered value, run length and the change flag together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q  <= 1'b0;
            run_q   <= '0;
            changed <= 1'b0;
        end else begin
            filt_q  <= filt_nxt;
            run_q   <= run_nxt;
            changed <= (filt_nxt != filt_q);
        end
    end

    assign filtered = filt_q;

endmodule

// File: rtl/usb_rx_linestate.sv
// USB receive front-end: deglitches D+ and D-, decodes the line state and
// flags line changes, bus reset (long SE0) and suspend (long idle J).
module usb_rx_linestate
    import usb_rx_linestate_pkg::*;
#(
    parameter int SAMPLES     = 2,
    parameter int FILT_LEN    = 2,
    parameter int LOW_SPEED   = 0,
    parameter int RST_CYCLES  = USB_DEFAULT_RST_CYCLES,
    parameter int SUSP_CYCLES = USB_DEFAULT_SUSP_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SAMPLES-1:0] rx_dp_s,
    input  logic [SAMPLES-1:0] rx_dn_s,
    output logic               rx_dp,
    output logic               rx_dn,
    output logic [1:0]         rx_state,
    output logic               rx_chg,
    output logic               bus_rst,
    output logic               suspend
);

    localparam int SE0_W  = $clog2(RST_CYCLES + 1);
    localparam int IDLE_W = $clog2(SUSP_CYCLES + 1);

    // Timeouts of zero would make bus_rst/suspend meaningless
    if (RST_CYCLES < 1 || SUSP_CYCLES < 1) begin : g_bad_timeouts
        $error("usb_rx_linestate: RST_CYCLES and SUSP_CYCLES must be >= 1");
    end

    logic            dp_chg;
    logic            dn_chg;
    usb_line_state_e line_state;
    logic [SE0_W-1:0]  se0_cnt;
    logic [IDLE_W-1:0] idle_cnt;

    usb_line_filt #(
        .SAMPLES  (SAMPLES),
        .FILT_LEN (FILT_LEN)
    ) u_filt_dp (
        .clk      (clk),
        .rst      (rst),
        .samples  (rx_dp_s),
        .filtered (rx_dp),
        .changed  (dp_chg)
    );

    usb_line_filt #(
        .SAMPLES  (SAMPLES),
        .FILT_LEN (FILT_LEN)
    ) u_filt_dn (
        .clk      (clk),
        .rst      (rst),
        .samples  (rx_dn_s),
        .filtered (rx_dn),
        .changed  (dn_chg)
    );

    // Both change flags are registered, so one pulse covers a joint flip
    assign rx_chg     = dp_chg | dn_chg;
    assign line_state = decode_line_state(rx_dp, rx_dn, LOW_SPEED != 0);
    assign rx_state   = line_state;

    // Count consecutive SE0 cycles, saturating at the bus-reset threshold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            se0_cnt <= '0;
        end else if (line_state == USB_LS_SE0) begin
            if (se0_cnt != SE0_W'(RST_CYCLES)) begin
                se0_cnt <= se0_cnt + 1'b1;
            end
        end else begin
            se0_cnt <= '0;
        end
    end

    // Count consecutive idle-J cycles, saturating at the suspend threshold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (line_state == USB_LS_J) begin
            if (idle_cnt != IDLE_W'(SUSP_CYCLES)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end else begin
            idle_cnt <= '0;
        end
    end

    assign bus_rst = (se0_cnt == SE0_W'(RST_CYCLES));
    assign suspend = (idle_cnt == IDLE_W'(SUSP_CYCLES));

endmodule

// File: tb/tb_usb_rx_linestate.sv
// Testbench for usb_rx_linestate: four differently parameterised instances
// share one stimulus stream and are compared each cycle against a history
// based reference model, plus constant-expectation vectors and sequences.
module tb_usb_rx_linestate;

    localparam int NI = 4;
    localparam int P_S    [NI] = '{2, 2, 4, 1};
    localparam int P_F    [NI] = '{2, 2, 3, 1};
    localparam int P_LS   [NI] = '{0, 1, 0, 0};
    localparam int P_RST  [NI] = '{120, 120, 20, 5};
    localparam int P_SUSP [NI] = '{1000, 1000, 30, 7};

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dp_v;
    logic [3:0] dn_v;

    logic       o_dp   [NI];
    logic       o_dn   [NI];
    logic [1:0] o_st   [NI];
    logic       o_chg  [NI];
    logic       o_brst [NI];
    logic       o_susp [NI];

    int checks = 0;
    int errors = 0;

    // Reference model: raw sample history per line, filtered value,
    // and lengths of the current SE0 / J stretches
    int unsigned mh [NI][2];
    bit          mf [NI][2];
    bit          mchg [NI];
    int          se0_run [NI];
    int          j_run [NI];

    always #5 clk = ~clk;

    usb_rx_linestate #(.SAMPLES(2), .FILT_LEN(2), .LOW_SPEED(0),
                       .RST_CYCLES(120), .SUSP_CYCLES(1000)) dut0 (
        .clk(clk), .rst(rst), .rx_dp_s(dp_v[1:0]), .rx_dn_s(dn_v[1:0]),
        .rx_dp(o_dp[0]), .rx_dn(o_dn[0]), .rx_state(o_st[0]),
        .rx_chg(o_chg[0]), .bus_rst(o_brst[0]), .suspend(o_susp[0]));

    usb_rx_linestate #(.SAMPLES(2), .FILT_LEN(2), .LOW_SPEED(1),
                       .RST_CYCLES(120), .SUSP_CYCLES(1000)) dut1 (
        .clk(clk), .rst(rst), .rx_dp_s(dp_v[1:0]), .rx_dn_s(dn_v[1:0]),
        .rx_dp(o_dp[1]), .rx_dn(o_dn[1]), .rx_state(o_st[1]),
        .rx_chg(o_chg[1]), .bus_rst(o_brst[1]), .suspend(o_susp[1]));

    usb_rx_linestate #(.SAMPLES(4), .FILT_LEN(3), .LOW_SPEED(0),
                       .RST_CYCLES(20), .SUSP_CYCLES(30)) dut2 (
        .clk(clk), .rst(rst), .rx_dp_s(dp_v), .rx_dn_s(dn_v),
        .rx_dp(o_dp[2]), .rx_dn(o_dn[2]), .rx_state(o_st[2]),
        .rx_chg(o_chg[2]), .bus_rst(o_brst[2]), .suspend(o_susp[2]));

    usb_rx_linestate #(.SAMPLES(1), .FILT_LEN(1), .LOW_SPEED(0),
                       .RST_CYCLES(5), .SUSP_CYCLES(7)) dut3 (
        .clk(clk), .rst(rst), .rx_dp_s(dp_v[0:0]), .rx_dn_s(dn_v[0:0]),
        .rx_dp(o_dp[3]), .rx_dn(o_dn[3]), .rx_state(o_st[3]),
        .rx_chg(o_chg[3]), .bus_rst(o_brst[3]), .suspend(o_susp[3]));

    // One comparison: count it, report it when it does not hold
    task automatic cmp(input string nm, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s inst%0d got %0d expected %0d at %0t",
                     nm, inst, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_state(input int i);
        bit p = mf[i][0];
        bit n = mf[i][1];
        if (p == n) return p ? 2'd3 : 2'd0;
        // J is D+ high at full speed and D- high at low speed
        if (p ^ (P_LS[i] != 0)) return 2'd1;
        return 2'd2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mh[i][0] = 0; mh[i][1] = 0;
            mf[i][0] = 0; mf[i][1] = 0;
            mchg[i] = 0; se0_run[i] = 0; j_run[i] = 0;
        end
    endtask

    // Advance the model across one clock edge using the current inputs.
    // A line flips once its last FILT_LEN raw samples all disagree with it.
    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            logic [1:0] st = model_state(i);
            bit od = mf[i][0];
            bit on = mf[i][1];
            se0_run[i] = (st == 2'd0) ? se0_run[i] + 1 : 0;
            j_run[i]   = (st == 2'd1) ? j_run[i] + 1 : 0;
            for (int ln = 0; ln < 2; ln++) begin
                for (int k = 0; k < P_S[i]; k++) begin
                    int unsigned mask = (32'd1 << P_F[i]) - 1;
                    bit s = (ln == 0) ? dp_v[k] : dn_v[k];
                    mh[i][ln] = (mh[i][ln] << 1) | 32'(s);
                    if ((mh[i][ln] & mask) == (mf[i][ln] ? 0 : mask))
                        mf[i][ln] = ~mf[i][ln];
                end
            end
            mchg[i] = (od != mf[i][0]) || (on != mf[i][1]);
        end
    endtask

    task automatic checkOutput();
        for (int i = 0; i < NI; i++) begin
            cmp("rx_dp", i, 32'(o_dp[i]), 32'(mf[i][0]));
            cmp("rx_dn", i, 32'(o_dn[i]), 32'(mf[i][1]));
            cmp("rx_state", i, 32'(o_st[i]), 32'(model_state(i)));
            cmp("rx_chg", i, 32'(o_chg[i]), 32'(mchg[i]));
            cmp("bus_rst", i, 32'(o_brst[i]), 32'(se0_run[i] >= P_RST[i]));
            cmp("suspend", i, 32'(o_susp[i]), 32'(j_run[i] >= P_SUSP[i]));
        end
    endtask

    // Drive one cycle of samples, clock it, then check against the model
    task automatic applyStimulus(input logic [3:0] dp, input logic [3:0] dn);
        dp_v = dp;
        dn_v = dn;
        @(posedge clk);
        model_step();
        #1;
        checkOutput();
    endtask

    typedef struct {
        logic [1:0] dp;
        logic [1:0] dn;
        logic       e_dp;
        logic       e_dn;
        logic [1:0] e_st;
        logic [1:0] e_st_ls;
        logic       e_chg;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic lvl_dp, lvl_dn;
        logic [3:0] sdp, sdn;

        // dp, dn, exp dp, exp dn, exp state (FS), exp state (LS), exp chg
        tbl[0]  = '{2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[1]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'd1, 2'd2, 1'b1};
        tbl[2]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'd1, 2'd2, 1'b0};
        tbl[3]  = '{2'b10, 2'b00, 1'b1, 1'b0, 2'd1, 2'd2, 1'b0};
        tbl[4]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'd1, 2'd2, 1'b0};
        tbl[5]  = '{2'b01, 2'b00, 1'b1, 1'b0, 2'd1, 2'd2, 1'b0};
        tbl[6]  = '{2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1};
        tbl[7]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'd1, 2'd2, 1'b1};
        tbl[8]  = '{2'b00, 2'b11, 1'b0, 1'b1, 2'd2, 2'd1, 1'b1};
        tbl[9]  = '{2'b00, 2'b11, 1'b0, 1'b1, 2'd2, 2'd1, 1'b0};
        tbl[10] = '{2'b00, 2'b10, 1'b0, 1'b1, 2'd2, 2'd1, 1'b0};
        tbl[11] = '{2'b11, 2'b11, 1'b1, 1'b1, 2'd3, 2'd3, 1'b1};
        tbl[12] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1};

        // Reset state
        rst = 1'b1;
        dp_v = 4'h0;
        dn_v = 4'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_dp", 0, 32'(o_dp[0]), 0);
        cmp("reset_state", 0, 32'(o_st[0]), 0);
        cmp("reset_chg", 0, 32'(o_chg[0]), 0);
        cmp("reset_bus_rst", 0, 32'(o_brst[0]), 0);
        cmp("reset_suspend", 0, 32'(o_susp[0]), 0);
        checkOutput();
        #2 rst = 1'b0;

        // Bus reset rises exactly RST_CYCLES after release with SE0 held
        for (int c = 1; c <= 125; c++) begin
            applyStimulus(4'h0, 4'h0);
            cmp("bus_rst_rise", 0, 32'(o_brst[0]), 32'(c >= 120));
        end
        $display("[TB] bus reset sequence done");

        // Table vectors: filtering, split runs, joint flips, J/K per speed
        for (int v = 0; v < 13; v++) begin
            applyStimulus({tbl[v].dp, tbl[v].dp}, {tbl[v].dn, tbl[v].dn});
            cmp("tbl_dp", 0, 32'(o_dp[0]), 32'(tbl[v].e_dp));
            cmp("tbl_dn", 0, 32'(o_dn[0]), 32'(tbl[v].e_dn));
            cmp("tbl_state", 0, 32'(o_st[0]), 32'(tbl[v].e_st));
            cmp("tbl_chg", 0, 32'(o_chg[0]), 32'(tbl[v].e_chg));
            cmp("tbl_state_ls", 1, 32'(o_st[1]), 32'(tbl[v].e_st_ls));
            cmp("tbl_chg_ls", 1, 32'(o_chg[1]), 32'(tbl[v].e_chg));
        end
        $display("[TB] vector table done");

        // Suspend after SUSP_CYCLES of J, cleared by one K, then restart
        applyStimulus(4'hF, 4'h0);
        cmp("susp_enter_j", 0, 32'(o_st[0]), 1);
        for (int c = 1; c <= 1000; c++) begin
            applyStimulus(4'hF, 4'h0);
            if (c >= 999) cmp("suspend_rise", 0, 32'(o_susp[0]), 32'(c == 1000));
        end
        applyStimulus(4'h0, 4'hF);
        cmp("susp_k_state", 0, 32'(o_st[0]), 2);
        cmp("susp_k_hold", 0, 32'(o_susp[0]), 1);
        applyStimulus(4'hF, 4'h0);
        cmp("susp_cleared", 0, 32'(o_susp[0]), 0);
        for (int c = 1; c <= 1000; c++) begin
            applyStimulus(4'hF, 4'h0);
            if (c >= 999) cmp("suspend_restart", 0, 32'(o_susp[0]), 32'(c == 1000));
        end
        $display("[TB] suspend sequence done");

        // Reset in the middle of an SE0 stretch
        applyStimulus(4'h0, 4'h0);
        for (int c = 1; c <= 60; c++) applyStimulus(4'h0, 4'h0);
        cmp("pre_reset_bus_rst3", 3, 32'(o_brst[3]), 1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        cmp("midrst_bus_rst0", 0, 32'(o_brst[0]), 0);
        cmp("midrst_bus_rst3", 3, 32'(o_brst[3]), 0);
        cmp("midrst_chg", 0, 32'(o_chg[0]), 0);
        checkOutput();
        @(posedge clk);
        #3 rst = 1'b0;
        for (int c = 1; c <= 122; c++) begin
            applyStimulus(4'h0, 4'h0);
            if (c >= 119) cmp("bus_rst_after_rst", 0, 32'(o_brst[0]), 32'(c >= 120));
        end
        $display("[TB] mid-operation reset done");

        // Four samples per clock, FILT_LEN=3, run split across two cycles
        applyStimulus(4'hF, 4'h0);
        cmp("s4_set", 2, 32'(o_dp[2]), 1);
        applyStimulus(4'b0111, 4'h0);
        cmp("s4_hold", 2, 32'(o_dp[2]), 1);
        cmp("s4_hold_chg", 2, 32'(o_chg[2]), 0);
        applyStimulus(4'b0000, 4'h0);
        cmp("s4_flip", 2, 32'(o_dp[2]), 0);
        cmp("s4_flip_chg", 2, 32'(o_chg[2]), 1);
        // FILT_LEN=1 passes every change straight through
        applyStimulus(4'b0001, 4'h0);
        cmp("f1_rise", 3, 32'(o_dp[3]), 1);
        cmp("f1_rise_chg", 3, 32'(o_chg[3]), 1);
        applyStimulus(4'b0000, 4'h0);
        cmp("f1_fall", 3, 32'(o_dp[3]), 0);
        cmp("f1_fall_chg", 3, 32'(o_chg[3]), 1);

        // Randomised traffic: slowly wandering levels with sparse glitches
        lvl_dp = 1'b1;
        lvl_dn = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) lvl_dp = ~lvl_dp;
            if ($urandom_range(0, 7) == 0) lvl_dn = ~lvl_dn;
            sdp = {4{lvl_dp}};
            sdn = {4{lvl_dn}};
            if ($urandom_range(0, 4) == 0) sdp = sdp ^ (4'd1 << $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) sdn = sdn ^ (4'd1 << $urandom_range(0, 3));
            applyStimulus(sdp, sdn);
        end
        $display("[TB] random traffic done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
